// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// Pure definitions: no latency, no flow control.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        RST_S_RESET,
        RST_S_RELEASE,
        RST_S_RUN
    } rst_state_t;

    localparam int RST_COUNT_W = 8;
    localparam logic [RST_COUNT_W-1:0] RST_COUNT_MAX = '1;

    function automatic logic [RST_COUNT_W-1:0] rst_count_inc(input logic [RST_COUNT_W-1:0] val);
        return (val == RST_COUNT_MAX) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/rst_sequencer_sync_bit.sv
// Multi-flop single-bit synchroniser with a configurable reset value.
// Latency DEPTH cycles; no flow control.
module sync_bit #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk_in,
    input  logic sys_rst_n_in,
    input  logic d_in,
    output logic q_out
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge sys_clk_in) begin
        if (!sys_rst_n_in) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_in};
        end
    end

    assign q_out = sync_q[DEPTH-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: qualifies lock/ext reset/sw request, holds reset, then releases outputs staggered.
// Fault to all-reset in 1 cycle after the synced fault; no backpressure, outputs are registered.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_RST_OUT = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_DELAY = 8
) (
    input  logic                   sys_clk_in,
    input  logic                   sys_rst_n_in,
    input  logic                   mmcm_lock_in,
    input  logic                   ext_rst_in,
    input  logic                   sw_rst_req_in,
    output logic [NUM_RST_OUT-1:0] rst_out,
    output logic                   rst_done_out,
    output logic [1:0]             state_out,
    output logic [RST_COUNT_W-1:0] rst_count_out
);

    localparam int FILT_W  = $clog2(LOCK_FILTER + 1);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int STAGE_W = $clog2(STAGE_DELAY + 1);
    localparam int IDX_W   = $clog2(NUM_RST_OUT + 1);

    localparam logic [FILT_W-1:0]  FILT_MAX   = FILT_W'(LOCK_FILTER);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_RST_OUT - 1);

    logic lock_sync;
    logic ext_sync;
    logic lock_ok;
    logic fault;

    logic [FILT_W-1:0] filt_cnt_q;

    rst_state_t                 state_q,     state_nxt;
    logic [HOLD_W-1:0]          hold_cnt_q,  hold_cnt_nxt;
    logic [STAGE_W-1:0]         stage_cnt_q, stage_cnt_nxt;
    logic [IDX_W-1:0]           idx_q,       idx_nxt;
    logic [NUM_RST_OUT-1:0]     rst_q,       rst_nxt;
    logic                       done_q,      done_nxt;
    logic [RST_COUNT_W-1:0]     count_q,     count_nxt;

    sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
        .sys_clk_in   (sys_clk_in),
        .sys_rst_n_in (sys_rst_n_in),
        .d_in         (mmcm_lock_in),
        .q_out        (lock_sync)
    );

    sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_ext_sync (
        .sys_clk_in   (sys_clk_in),
        .sys_rst_n_in (sys_rst_n_in),
        .d_in         (ext_rst_in),
        .q_out        (ext_sync)
    );

    always_ff @(posedge sys_clk_in) begin
        if (!sys_rst_n_in) begin
            filt_cnt_q <= '0;
        end else if (!lock_sync) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q != FILT_MAX) begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    // A synced low drops trust immediately, not one cycle after the counter clears.
    assign lock_ok = lock_sync && (filt_cnt_q == FILT_MAX);
    assign fault   = !lock_ok || ext_sync || sw_rst_req_in;

    always_ff @(posedge sys_clk_in) begin
        if (!sys_rst_n_in) begin
            state_q     <= RST_S_RESET;
            hold_cnt_q  <= '0;
            stage_cnt_q <= '0;
            idx_q       <= '0;
            rst_q       <= '1;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_nxt;
            hold_cnt_q  <= hold_cnt_nxt;
            stage_cnt_q <= stage_cnt_nxt;
            idx_q       <= idx_nxt;
            rst_q       <= rst_nxt;
            done_q      <= done_nxt;
            count_q     <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            RST_S_RESET: begin
                if (!fault && hold_cnt_q == HOLD_LAST) state_nxt = RST_S_RELEASE;
            end
            RST_S_RELEASE: begin
                if (fault) begin
                    state_nxt = RST_S_RESET;
                end else if (stage_cnt_q == STAGE_LAST && idx_q == IDX_LAST) begin
                    state_nxt = RST_S_RUN;
                end
            end
            RST_S_RUN: begin
                if (fault) state_nxt = RST_S_RESET;
            end
            default: state_nxt = RST_S_RESET;
        endcase
    end

    always_comb begin
        hold_cnt_nxt  = hold_cnt_q;
        stage_cnt_nxt = stage_cnt_q;
        idx_nxt       = idx_q;
        rst_nxt       = rst_q;
        done_nxt      = done_q;
        count_nxt     = count_q;
        case (state_q)
            RST_S_RESET: begin
                rst_nxt       = '1;
                done_nxt      = 1'b0;
                stage_cnt_nxt = '0;
                idx_nxt       = '0;
                if (fault || hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt_q + 1'b1;
                end
            end
            RST_S_RELEASE: begin
                hold_cnt_nxt = '0;
                // Fault takes priority over a coinciding terminal count.
                if (fault) begin
                    rst_nxt       = '1;
                    done_nxt      = 1'b0;
                    stage_cnt_nxt = '0;
                    idx_nxt       = '0;
                    count_nxt     = rst_count_inc(count_q);
                end else if (stage_cnt_q == STAGE_LAST) begin
                    for (int i = 0; i < NUM_RST_OUT; i++) begin
                        if (idx_q == IDX_W'(i)) rst_nxt[i] = 1'b0;
                    end
                    stage_cnt_nxt = '0;
                    idx_nxt       = idx_q + 1'b1;
                    done_nxt      = (idx_q == IDX_LAST);
                end else begin
                    stage_cnt_nxt = stage_cnt_q + 1'b1;
                end
            end
            RST_S_RUN: begin
                hold_cnt_nxt  = '0;
                stage_cnt_nxt = '0;
                idx_nxt       = '0;
                if (fault) begin
                    rst_nxt   = '1;
                    done_nxt  = 1'b0;
                    count_nxt = rst_count_inc(count_q);
                end else begin
                    rst_nxt  = '0;
                    done_nxt = 1'b1;
                end
            end
            default: begin
                hold_cnt_nxt  = '0;
                stage_cnt_nxt = '0;
                idx_nxt       = '0;
                rst_nxt       = '1;
                done_nxt      = 1'b0;
            end
        endcase
    end

    assign rst_out       = rst_q;
    assign rst_done_out  = done_q;
    assign state_out     = state_q;
    assign rst_count_out = count_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with NUM_RST_OUT=3, SYNC_STAGES=2, LOCK_FILTER=4, HOLD_CYCLES=16, STAGE_DELAY=8.
// Edge k counts rising edges after sys_rst_n_in is released; RELEASE is entered at edge 22 for a clean cold start.
module tb_rst_sequencer;

    logic       sys_clk_in = 1'b0;
    logic       sys_rst_n_in;
    logic       mmcm_lock_in;
    logic       ext_rst_in;
    logic       sw_rst_req_in;
    logic [2:0] rst_out;
    logic       rst_done_out;
    logic [1:0] state_out;
    logic [7:0] rst_count_out;

    int vectors    = 0;
    int miscompares = 0;

    always #5 sys_clk_in = ~sys_clk_in;

    rst_sequencer #(
        .NUM_RST_OUT (3),
        .SYNC_STAGES (2),
        .LOCK_FILTER (4),
        .HOLD_CYCLES (16),
        .STAGE_DELAY (8)
    ) dut (
        .sys_clk_in    (sys_clk_in),
        .sys_rst_n_in  (sys_rst_n_in),
        .mmcm_lock_in  (mmcm_lock_in),
        .ext_rst_in    (ext_rst_in),
        .sw_rst_req_in (sw_rst_req_in),
        .rst_out       (rst_out),
        .rst_done_out  (rst_done_out),
        .state_out     (state_out),
        .rst_count_out (rst_count_out)
    );

    task automatic tick();
        @(posedge sys_clk_in);
        #1;
    endtask

    task automatic block_reset();
        sys_rst_n_in = 1'b0;
        tick();
        tick();
        sys_rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n_in  = 1'b0;
        mmcm_lock_in  = 1'b1;
        ext_rst_in    = 1'b0;
        sw_rst_req_in = 1'b0;
        repeat (5) tick();
        vectors++;
        if (rst_out !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_rst_out got=%b exp=111", rst_out);
        end
        vectors++;
        if (rst_done_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done got=%b exp=0", rst_done_out);
        end
        vectors++;
        if (state_out !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state got=%b exp=00", state_out);
        end
        vectors++;
        if (rst_count_out !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_count got=%0d exp=0", rst_count_out);
        end
        sys_rst_n_in = 1'b1;
    endtask

    task automatic test_cold_start();
        logic [1:0] exp_state;
        logic [2:0] exp_rst;
        logic       exp_done;
        for (int k = 1; k <= 50; k++) begin
            tick();
            exp_state = (k < 22) ? 2'b00 : (k < 46) ? 2'b01 : 2'b10;
            exp_rst   = (k < 30) ? 3'b111 : (k < 38) ? 3'b110 : (k < 46) ? 3'b100 : 3'b000;
            exp_done  = (k >= 46);
            vectors++;
            if ({state_out, rst_out, rst_done_out} !== {exp_state, exp_rst, exp_done}) begin
                miscompares++;
                $display("FAIL cold_start k=%0d got state=%b rst=%b done=%b exp state=%b rst=%b done=%b",
                         k, state_out, rst_out, rst_done_out, exp_state, exp_rst, exp_done);
            end
        end
        vectors++;
        if (rst_count_out !== 8'd0) begin
            miscompares++;
            $display("FAIL cold_start_count got=%0d exp=0", rst_count_out);
        end
    endtask

    task automatic test_lock_glitch_reset();
        block_reset();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 16) mmcm_lock_in = 1'b0;
            if (k == 17) mmcm_lock_in = 1'b1;
            if (k == 38) begin
                vectors++;
                if ({state_out, rst_out} !== {2'b00, 3'b111}) begin
                    miscompares++;
                    $display("FAIL lock_glitch_held got state=%b rst=%b exp state=00 rst=111", state_out, rst_out);
                end
            end
            if (k == 39) begin
                vectors++;
                if ({state_out, rst_out} !== {2'b01, 3'b111}) begin
                    miscompares++;
                    $display("FAIL lock_glitch_release got state=%b rst=%b exp state=01 rst=111", state_out, rst_out);
                end
            end
        end
        vectors++;
        if (rst_count_out !== 8'd0) begin
            miscompares++;
            $display("FAIL lock_glitch_count got=%0d exp=0", rst_count_out);
        end
    endtask

    task automatic test_lock_loss_run();
        block_reset();
        repeat (46) tick();
        vectors++;
        if ({rst_out, rst_done_out} !== {3'b000, 1'b1}) begin
            miscompares++;
            $display("FAIL lock_loss_pre got rst=%b done=%b exp rst=000 done=1", rst_out, rst_done_out);
        end
        mmcm_lock_in = 1'b0;
        tick();
        tick();
        vectors++;
        if ({rst_out, rst_done_out} !== {3'b000, 1'b1}) begin
            miscompares++;
            $display("FAIL lock_loss_early got rst=%b done=%b exp rst=000 done=1", rst_out, rst_done_out);
        end
        tick();
        vectors++;
        if ({rst_out, rst_done_out, state_out, rst_count_out} !== {3'b111, 1'b0, 2'b00, 8'd1}) begin
            miscompares++;
            $display("FAIL lock_loss_assert got rst=%b done=%b state=%b count=%0d exp rst=111 done=0 state=00 count=1",
                     rst_out, rst_done_out, state_out, rst_count_out);
        end
        mmcm_lock_in = 1'b1;
        for (int j = 1; j <= 46; j++) begin
            tick();
            if (j == 21) begin
                vectors++;
                if (state_out !== 2'b00) begin
                    miscompares++;
                    $display("FAIL lock_loss_resequence_hold got=%b exp=00", state_out);
                end
            end
            if (j == 22) begin
                vectors++;
                if (state_out !== 2'b01) begin
                    miscompares++;
                    $display("FAIL lock_loss_resequence_release got=%b exp=01", state_out);
                end
            end
        end
        vectors++;
        if ({rst_out, rst_done_out, rst_count_out} !== {3'b000, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL lock_loss_rerun got rst=%b done=%b count=%0d exp rst=000 done=1 count=1",
                     rst_out, rst_done_out, rst_count_out);
        end
    endtask

    task automatic test_sw_mid_release();
        block_reset();
        repeat (31) tick();
        vectors++;
        if ({state_out, rst_out} !== {2'b01, 3'b110}) begin
            miscompares++;
            $display("FAIL sw_mid_pre got state=%b rst=%b exp state=01 rst=110", state_out, rst_out);
        end
        sw_rst_req_in = 1'b1;
        tick();
        sw_rst_req_in = 1'b0;
        vectors++;
        if ({state_out, rst_out, rst_count_out} !== {2'b00, 3'b111, 8'd1}) begin
            miscompares++;
            $display("FAIL sw_mid_assert got state=%b rst=%b count=%0d exp state=00 rst=111 count=1",
                     state_out, rst_out, rst_count_out);
        end

        // Pulse lands on the first terminal count: nothing may be released.
        block_reset();
        repeat (29) tick();
        vectors++;
        if ({state_out, rst_out} !== {2'b01, 3'b111}) begin
            miscompares++;
            $display("FAIL sw_tc_pre got state=%b rst=%b exp state=01 rst=111", state_out, rst_out);
        end
        sw_rst_req_in = 1'b1;
        tick();
        sw_rst_req_in = 1'b0;
        vectors++;
        if ({state_out, rst_out, rst_count_out} !== {2'b00, 3'b111, 8'd1}) begin
            miscompares++;
            $display("FAIL sw_tc_fault_wins got state=%b rst=%b count=%0d exp state=00 rst=111 count=1",
                     state_out, rst_out, rst_count_out);
        end
    endtask

    task automatic test_multi_fault();
        block_reset();
        repeat (46) tick();
        mmcm_lock_in = 1'b0;
        ext_rst_in   = 1'b1;
        tick();
        tick();
        sw_rst_req_in = 1'b1;
        tick();
        sw_rst_req_in = 1'b0;
        vectors++;
        if ({rst_out, rst_count_out} !== {3'b111, 8'd1}) begin
            miscompares++;
            $display("FAIL multi_fault_once got rst=%b count=%0d exp rst=111 count=1", rst_out, rst_count_out);
        end
        repeat (3) tick();
        vectors++;
        if (rst_count_out !== 8'd1) begin
            miscompares++;
            $display("FAIL multi_fault_in_reset got=%0d exp=1", rst_count_out);
        end
        mmcm_lock_in = 1'b1;
        ext_rst_in   = 1'b0;
    endtask

    task automatic test_ext_hold();
        ext_rst_in = 1'b1;
        block_reset();
        repeat (100) tick();
        vectors++;
        if ({state_out, rst_out} !== {2'b00, 3'b111}) begin
            miscompares++;
            $display("FAIL ext_hold got state=%b rst=%b exp state=00 rst=111", state_out, rst_out);
        end
        ext_rst_in = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            tick();
            if (j == 17) begin
                vectors++;
                if (state_out !== 2'b00) begin
                    miscompares++;
                    $display("FAIL ext_release_early got=%b exp=00", state_out);
                end
            end
            if (j == 18) begin
                vectors++;
                if (state_out !== 2'b01) begin
                    miscompares++;
                    $display("FAIL ext_release got=%b exp=01", state_out);
                end
            end
        end
        vectors++;
        if (rst_count_out !== 8'd0) begin
            miscompares++;
            $display("FAIL ext_count got=%0d exp=0", rst_count_out);
        end
    endtask

    task automatic test_saturation();
        int w;
        block_reset();
        repeat (46) tick();
        for (int n = 1; n <= 300; n++) begin
            sw_rst_req_in = 1'b1;
            tick();
            sw_rst_req_in = 1'b0;
            if (n == 254) begin
                vectors++;
                if (rst_count_out !== 8'd254) begin
                    miscompares++;
                    $display("FAIL sat_count_254 got=%0d exp=254", rst_count_out);
                end
            end
            w = 0;
            while (rst_done_out !== 1'b1 && w < 60) begin
                tick();
                w++;
            end
            vectors++;
            if (rst_done_out !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_rerun_timeout n=%0d done=%b exp=1", n, rst_done_out);
            end
        end
        vectors++;
        if (rst_count_out !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_count got=%0d exp=255", rst_count_out);
        end
    endtask

    task automatic test_block_reset_run();
        sys_rst_n_in = 1'b0;
        tick();
        sys_rst_n_in = 1'b1;
        vectors++;
        if ({rst_out, rst_done_out, state_out, rst_count_out} !== {3'b111, 1'b0, 2'b00, 8'd0}) begin
            miscompares++;
            $display("FAIL block_reset_run got rst=%b done=%b state=%b count=%0d exp rst=111 done=0 state=00 count=0",
                     rst_out, rst_done_out, state_out, rst_count_out);
        end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_lock_glitch_reset();
        test_lock_loss_run();
        test_sw_mid_release();
        test_multi_fault();
        test_ext_hold();
        test_saturation();
        test_block_reset_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset sequencer for one clock domain: the next generation of the team's clock/reset generation. It synchronises the MMCM lock and an external reset pin, filters lock glitches, and enforces a minimum reset hold time. It then releases `NUM_RST_OUT` active-high resets in a staggered order (BRAM, SPI, user logic, …). It sits directly after the clock wizard, one instance per generated clock.

## Interface
- `NUM_RST_OUT`, 4: number of sequenced reset outputs, ≥1
- `SYNC_STAGES`, 2: synchroniser depth for async inputs, ≥2
- `LOCK_FILTER`, 4: consecutive synced-high lock cycles required before lock is trusted, ≥1
- `HOLD_CYCLES`, 16: minimum fault-free cycles in RESET before release, ≥1
- `STAGE_DELAY`, 8: cycles between successive output releases, ≥1

Ports:
- `sys_clk_in`  in  1: the single clock; everything is on its rising edge
- `sys_rst_n_in`  in  1: synchronous, active-low block reset
- `mmcm_lock_in`  in  1: MMCM locked, asynchronous
- `ext_rst_in`  in  1: external reset, active-high, asynchronous
- `sw_rst_req_in`  in  1: software reset request, synchronous, any width pulse
- `rst_out`  out  NUM_RST_OUT: sequenced resets, active-high; bit 0 released first
- `rst_done_out`  out  1: all resets released (state RUN)
- `state_out`  out  2: current FSM state encoding
- `rst_count_out`  out  8: saturating count of fault-induced re-resets

## Operation
- **Synchronisers.**
  - `mmcm_lock_in` passes through SYNC_STAGES flops, reset value 0.
  - `ext_rst_in` passes through SYNC_STAGES flops, reset value 1.
- **Lock filter.**
  - The filter counter increments while synced lock is 1, saturating at LOCK_FILTER.
  - `lock_ok` = 1 when the counter equals LOCK_FILTER.
  - Synced lock 0 clears the counter and `lock_ok` in the same cycle.
- **Fault.** `fault = !lock_ok | ext_sync | sw_rst_req_in`, combinational, fed to the FSM.
- **FSM states.** RESET=2'b00, RELEASE=2'b01, RUN=2'b10. 2'b11 is unused and recovers to RESET.
- **RESET.**
  - All `rst_out` are 1.
  - The hold counter clears on fault and increments otherwise.
  - At hold count HOLD_CYCLES-1 with no fault, go to RELEASE with stage counter = 0 and index = 0.
- **RELEASE.**
  - The stage counter counts 0..STAGE_DELAY-1.
  - At terminal count, clear `rst_out[index]`, increment index and restart the stage counter.
  - When index NUM_RST_OUT-1 is released, go to RUN and set `rst_done_out`.
- **RUN.** All `rst_out` are 0 and `rst_done_out` is 1.
- **Fault in RELEASE or RUN.**
  - On the next edge, all `rst_out` go to 1, `rst_done_out` goes to 0 and the state goes to RESET.
  - All counters clear.
  - `rst_count_out` increments, saturating at 255.
- **Fault in RESET.** Only restarts the hold counter; `rst_count_out` does not change.
- **Simultaneous events.**
  - If fault and a release terminal count coincide, fault wins and no bit is released.
  - Multiple fault sources in one cycle count once.
- **`sys_rst_n_in` = 0.** On the next edge, every register takes its reset value: `rst_out` all 1, `rst_done_out` 0, `state_out` 2'b00, `rst_count_out` 0, sync/filter/hold/stage counters 0 (ext sync 1). This is not counted as a fault.
- **Counter widths.** Each counter is `$clog2(limit+1)` bits; no counter wraps.

## Timing
- **Release order.** If RELEASE is first occupied in cycle T, `rst_out[k]` is low from cycle T+(k+1)·STAGE_DELAY.
- **Completion.** `rst_done_out` rises in the same cycle as `rst_out[NUM_RST_OUT-1]` falls.
- **Pin to reset assertion.**
  - `ext_rst_in` or `mmcm_lock_in` pin edge to `rst_out` all-1: SYNC_STAGES+1 cycles.
  - `sw_rst_req_in` to `rst_out` all-1: 1 cycle.
- **Cold start.** From a `sys_rst_n_in` release with a stable lock and no ext reset, RELEASE is entered after SYNC_STAGES + LOCK_FILTER + HOLD_CYCLES cycles, ±1.
- **Registered outputs.** All outputs are registered and glitch-free; there are no combinational paths from any input to any output.

## Structure
- **Package `rst_seq_pkg`.**
  - `typedef enum logic [1:0] {RST_S_RESET, RST_S_RELEASE, RST_S_RUN} rst_state_t`.
  - `localparam RST_COUNT_W = 8`.
- **Sub-module `sync_bit`.** Parametrised by depth and reset value; instantiated twice.
- **Top level.** Contains the filter, hold/stage counters, FSM and fault counter.

## Test plan
All scenarios use NUM_RST_OUT=3, SYNC_STAGES=2, LOCK_FILTER=4, HOLD_CYCLES=16, STAGE_DELAY=8.
- **Cold start.** `sys_rst_n_in` low 5 cycles, lock=1, ext=0 -> `rst_out` 111->110->100->000 at 8-cycle spacing; `rst_done_out`=1 with the last release; `rst_count_out`=0.
- **Lock glitch in RESET.** 1-cycle lock=0 at hold count 10 -> hold restarts; release is delayed by ≥16 cycles; `rst_count_out` stays 0.
- **Lock loss in RUN.** Lock pin goes low -> `rst_out`=111 and `rst_done_out`=0 3 cycles later; `rst_count_out`=1; a full re-sequence follows lock return.
- **SW reset mid-RELEASE.** `sw_rst_req_in` 1-cycle pulse after `rst_out`=110 -> 111 next cycle; `state_out`=00; count increments. A pulse coinciding with a terminal count releases nothing.
- **Ext reset hold and counter saturation.**
  - `ext_rst_in` high for 100 cycles -> `rst_out` stays 111; release starts 16 cycles after the synced deassert.
  - 300 sw faults in RUN -> `rst_count_out`=255.
- **Block reset mid-RUN.** `sys_rst_n_in` low for 1 cycle -> next cycle all outputs at reset values, including `rst_count_out`=0.
